r_msg_store: RTL and testbench
==============================

Name: r_msg_store

Overview:
- Parametrised check-to-variable (R) message store for the layered QC-LDPC decoder; successor to the fixed 16-layer R memory.
- Holds one R-message word per layer (Z lanes x NCOL blocks x MSG_W bits).
- Independent wrapping read and write layer pointers, with an outstanding-layer count and per-layer valid bits.
- Never-written layers read as zero, so an iteration-0 clear is one cycle.
- Sits between the layer controller/CNU input register and the CNU output.

Parameters:
- Z, 64, circulant size (lanes per block).
- NCOL, 27, block columns per layer.
- MSG_W, 8, bits per message (iniBW+exBW).
- NLAYER, 16, layers per iteration (>=2).
- Derived: DW = Z*NCOL*MSG_W; AW = clog2(NLAYER); CW = clog2(NLAYER+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rst_r  in  1  synchronous active-low clear of all valid bits, pointers and count.
- iter_start  in  1  new iteration: pointers and count to 0; valid bits kept.
- rd_req  in  1  read layer at rd_ptr.
- rd_valid  out  1  rd_data valid (registered).
- rd_data  out  DW  R messages for the layer read.
- rd_layer  out  AW  layer index of the current rd_data.
- wr_en  in  1  write-back of the oldest outstanding layer.
- wr_data  in  DW  CNU output messages.
- outstanding  out  CW  reads issued minus writes done.
- err  out  1  one-cycle pulse: rejected read or write.

Behaviour:
- Reset (rst_n=0): rd_ptr=wr_ptr=0, outstanding=0, all valid bits=0, rd_valid=0, rd_data=0, rd_layer=0, err=0.
  - Storage array contents are don't-care; the valid bits mask them.
- Priority per cycle: rst_n > rst_r > iter_start > wr_en/rd_req.
  - rst_r=0: same clears as reset except rd_data holds its value; rd_valid=0; concurrent wr_en/rd_req ignored, no err.
  - iter_start=1: rd_ptr=wr_ptr=outstanding=0; rd_valid=0; concurrent wr_en/rd_req ignored, no err.
- Write acceptance: accepted iff outstanding(pre-cycle)>0.
  - mem[wr_ptr]<=wr_data; valid[wr_ptr]<=1; wr_ptr wraps NLAYER-1 -> 0.
  - Rejected write: dropped, err=1.
- Read acceptance: accepted iff outstanding(pre-cycle)<NLAYER.
  - Next cycle: rd_valid=1; rd_layer=rd_ptr(old).
  - rd_data = mem[rd_ptr] if valid[rd_ptr], else all zeros.
  - rd_ptr wraps NLAYER-1 -> 0.
  - Rejected read: rd_valid=0, err=1, rd_ptr unchanged.
- rd_valid is a 1-cycle pulse. rd_data holds its last value when rd_valid=0.
- outstanding' = outstanding + rd_accepted - wr_accepted. Simultaneous accepted read and write leaves it unchanged.
- Same-cycle read and write of different layers: the read returns old contents.
  - Read and write can hit the same layer only when outstanding==NLAYER; see Optional Feature.
- err is 1 if either request is rejected in the cycle. Both rejected still gives a single pulse.
- Latency: write to readable = 1 cycle; read request to data = 1 cycle.

Optional Feature:
- Macro: R_MSG_BYPASS_EN.
- Defined:
  - When outstanding==NLAYER, rd_req and wr_en in the same cycle are both accepted (rd_ptr==wr_ptr).
  - rd_data = wr_data of that cycle (forwarded); valid bit set; outstanding stays NLAYER; no err.
  - This allows a fully pipelined NLAYER-deep loop.
- Undefined: in that case the read is rejected (err=1) and the write is accepted. outstanding becomes NLAYER-1.

Test Plan:
- After reset, 16 rd_req pulses with no writes (NLAYER=16) -> rd_valid pulses with rd_data=0 and rd_layer 0..15, outstanding=16. A 17th rd_req -> err=1, rd_valid=0.
- Write each layer L with pattern {DW/8{L[7:0]}}, then iter_start, then read all 16 -> rd_data matches the pattern per layer and rd_layer wraps 15 -> 0.
- wr_en with outstanding=0 -> err=1, no valid bit set. A following read of that layer -> zeros.
- Write all layers, pulse rst_r=0 for one cycle, then read layer 0 -> rd_data=0; outstanding=0 after the clear.
- iter_start asserted with rd_req and wr_en in the same cycle -> no err, pointers=0, outstanding=0, rd_valid=0 next cycle.
- outstanding=16, rd_req and wr_en with wr_data=0xA5.. -> with R_MSG_BYPASS_EN: rd_data=0xA5.., err=0, outstanding=16. Without the macro: err=1, outstanding=15.

Source files
------------

// File: rtl/r_msg_store.sv
// R-message store for the layered QC-LDPC decoder: one word per layer, wrapping read/write layer pointers.
// Optional R_MSG_BYPASS_EN: a read and a write on a full store are both accepted, and the write data goes straight to rd_data.
module r_msg_store #(
  parameter int Z      = 64,
  parameter int NCOL   = 27,
  parameter int MSG_W  = 8,
  parameter int NLAYER = 16,
  localparam int DW = Z * NCOL * MSG_W,
  localparam int AW = $clog2(NLAYER),
  localparam int CW = $clog2(NLAYER + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rst_r,
  input  logic          iter_start,
  input  logic          rd_req,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] rd_layer,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic [CW-1:0] outstanding,
  output logic          err
);

  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [AW-1:0]     rd_ptr_nxt, wr_ptr_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [NLAYER-1:0] valid;
  logic [DW-1:0]     mem [NLAYER];

  logic          run;
  logic          full, empty;
  logic          byp;
  logic          rd_acc, wr_acc, rej;
  logic [DW-1:0] rd_word;

  // Clears and iteration restarts take priority and swallow any request made in the same cycle.
  assign run   = rst_r && !iter_start;
  assign full  = (cnt == CW'(NLAYER));
  assign empty = (cnt == '0);

`ifdef R_MSG_BYPASS_EN
  assign byp = full && rd_req && wr_en;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    rd_acc = run && rd_req && (!full || byp);
    wr_acc = run && wr_en && !empty;
    rej    = run && ((rd_req && !rd_acc) || (wr_en && !wr_acc));
  end

  always_comb begin
    rd_ptr_nxt = (rd_ptr == AW'(NLAYER - 1)) ? '0 : rd_ptr + 1'b1;
    wr_ptr_nxt = (wr_ptr == AW'(NLAYER - 1)) ? '0 : wr_ptr + 1'b1;
  end

  always_comb begin
    cnt_nxt = cnt;
    unique case ({rd_acc, wr_acc})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  // Layers never written since the last clear read back as zero.
  always_comb begin
    rd_word = '0;
    if (byp)
      rd_word = wr_data;
    else if (valid[rd_ptr])
      rd_word = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      valid    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_layer <= '0;
      err      <= 1'b0;
    end else if (!rst_r) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      valid    <= '0;
      rd_valid <= 1'b0;
      rd_layer <= '0;
      err      <= 1'b0;
    end else if (iter_start) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (wr_acc) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr_nxt;
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr_nxt;
        rd_data  <= rd_word;
        rd_layer <= rd_ptr;
      end
      rd_valid <= rd_acc;
      cnt      <= cnt_nxt;
      err      <= rej;
    end
  end

  assign outstanding = cnt;

endmodule

// File: tb/tb_r_msg_store.sv
// Scoreboard bench for r_msg_store at the default parameters; expected reads are queued when the request is driven.
module tb_r_msg_store;
  localparam int Z      = 64;
  localparam int NCOL   = 27;
  localparam int MSG_W  = 8;
  localparam int NLAYER = 16;
  localparam int DW     = Z * NCOL * MSG_W;
  localparam int AW     = $clog2(NLAYER);
  localparam int CW     = $clog2(NLAYER + 1);

  logic          clk = 1'b0;
  logic          rst_n, rst_r, iter_start, rd_req, wr_en;
  logic          rd_valid, err;
  logic [DW-1:0] rd_data, wr_data;
  logic [AW-1:0] rd_layer;
  logic [CW-1:0] outstanding;

  r_msg_store #(.Z(Z), .NCOL(NCOL), .MSG_W(MSG_W), .NLAYER(NLAYER)) dut (
    .clk(clk), .rst_n(rst_n), .rst_r(rst_r), .iter_start(iter_start),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_layer(rd_layer),
    .wr_en(wr_en), .wr_data(wr_data), .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] layer;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [DW-1:0] pat(input logic [7:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 8; i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  // One clock with the given requests; any read result is matched against the scoreboard head.
  task automatic step(input logic rd, input logic wr, input logic [DW-1:0] d);
    exp_t e;
    rd_req = rd; wr_en = wr; wr_data = d;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_en = 1'b0;
    if (rd_valid) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rd_valid: got rd_layer=%0d, required no read", rd_layer);
      end else begin
        e = sb.pop_front();
        if (rd_data !== e.data || rd_layer !== e.layer) begin
          n_fail++;
          $display("FAIL read_result: got layer=%0d data[31:0]=%h, required layer=%0d data[31:0]=%h",
                   rd_layer, rd_data[31:0], e.layer, e.data[31:0]);
        end
      end
    end else if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL missing_rd_valid: got rd_valid=0, required layer=%0d", sb[0].layer);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_r = 1'b1; iter_start = 1'b0;
    rd_req = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b, required 0", rd_valid); end
    n_tests++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h, required 0", rd_data[31:0]); end
    n_tests++; if (rd_layer !== '0) begin n_fail++; $display("FAIL reset_rd_layer: got %0d, required 0", rd_layer); end
    n_tests++; if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding: got %0d, required 0", outstanding); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0);
  endtask

  task automatic test_fill_reads();
    for (int l = 0; l < NLAYER; l++) begin
      sb.push_back('{data: '0, layer: AW'(l)});
      step(1'b1, 1'b0, '0);
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL fill_err: layer %0d got %b, required 0", l, err); end
    end
    n_tests++; if (outstanding !== CW'(NLAYER)) begin n_fail++; $display("FAIL fill_outstanding: got %0d, required %0d", outstanding, NLAYER); end
    step(1'b1, 1'b0, '0);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b, required 1", err); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL overflow_rd_valid: got %b, required 0", rd_valid); end
    n_tests++; if (outstanding !== CW'(NLAYER)) begin n_fail++; $display("FAIL overflow_outstanding: got %0d, required %0d", outstanding, NLAYER); end
    step(1'b0, 1'b0, '0);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b, required 0", err); end
  endtask

  task automatic test_write_pattern();
    for (int l = 0; l < NLAYER; l++) begin
      step(1'b0, 1'b1, pat(8'(l)));
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL write_err: layer %0d got %b, required 0", l, err); end
    end
    n_tests++; if (outstanding !== '0) begin n_fail++; $display("FAIL write_outstanding: got %0d, required 0", outstanding); end
    iter_start = 1'b1; step(1'b0, 1'b0, '0); iter_start = 1'b0;
    for (int l = 0; l < NLAYER; l++) begin
      sb.push_back('{data: pat(8'(l)), layer: AW'(l)});
      step(1'b1, 1'b0, '0);
    end
    // Free one slot so the read pointer can wrap from the last layer back to 0.
    step(1'b0, 1'b1, pat(8'h00));
    sb.push_back('{data: pat(8'h00), layer: '0});
    step(1'b1, 1'b0, '0);
    n_tests++; if (outstanding !== CW'(NLAYER)) begin n_fail++; $display("FAIL wrap_outstanding: got %0d, required %0d", outstanding, NLAYER); end
  endtask

  task automatic test_full_rw();
`ifdef R_MSG_BYPASS_EN
    sb.push_back('{data: pat(8'hA5), layer: AW'(1)});
    step(1'b1, 1'b1, pat(8'hA5));
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL bypass_err: got %b, required 0", err); end
    n_tests++; if (outstanding !== CW'(NLAYER)) begin n_fail++; $display("FAIL bypass_outstanding: got %0d, required %0d", outstanding, NLAYER); end
`else
    step(1'b1, 1'b1, pat(8'hA5));
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL full_rw_err: got %b, required 1", err); end
    n_tests++; if (outstanding !== CW'(NLAYER - 1)) begin n_fail++; $display("FAIL full_rw_outstanding: got %0d, required %0d", outstanding, NLAYER - 1); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL full_rw_rd_valid: got %b, required 0", rd_valid); end
`endif
    iter_start = 1'b1; step(1'b0, 1'b0, '0); iter_start = 1'b0;
    sb.push_back('{data: pat(8'h00), layer: '0});
    step(1'b1, 1'b0, '0);
    sb.push_back('{data: pat(8'hA5), layer: AW'(1)});
    step(1'b1, 1'b0, '0);
  endtask

  task automatic test_rst_r();
    rst_r = 1'b0; step(1'b1, 1'b1, pat(8'hFF)); rst_r = 1'b1;
    n_tests++; if (outstanding !== '0) begin n_fail++; $display("FAIL rst_r_outstanding: got %0d, required 0", outstanding); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_r_err: got %b, required 0", err); end
    n_tests++; if (rd_data !== pat(8'hA5)) begin n_fail++; $display("FAIL rst_r_hold: got %h, required %h", rd_data[31:0], 32'hA5A5A5A5); end
    sb.push_back('{data: '0, layer: '0});
    step(1'b1, 1'b0, '0);
  endtask

  task automatic test_wr_reject();
    iter_start = 1'b1; step(1'b0, 1'b0, '0); iter_start = 1'b0;
    step(1'b0, 1'b1, pat(8'h5A));
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL wr_reject_err: got %b, required 1", err); end
    n_tests++; if (outstanding !== '0) begin n_fail++; $display("FAIL wr_reject_outstanding: got %0d, required 0", outstanding); end
    sb.push_back('{data: '0, layer: '0});
    step(1'b1, 1'b0, '0);
  endtask

  task automatic test_iter_concurrent();
    iter_start = 1'b1; step(1'b1, 1'b1, pat(8'h77)); iter_start = 1'b0;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL iter_err: got %b, required 0", err); end
    n_tests++; if (outstanding !== '0) begin n_fail++; $display("FAIL iter_outstanding: got %0d, required 0", outstanding); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL iter_rd_valid: got %b, required 0", rd_valid); end
    sb.push_back('{data: '0, layer: '0});
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, pat(8'h3C));
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL write_back_err: got %b, required 0", err); end
    iter_start = 1'b1; step(1'b0, 1'b0, '0); iter_start = 1'b0;
    sb.push_back('{data: pat(8'h3C), layer: '0});
    step(1'b1, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    // Read of layer 1 and write-back of layer 0 in the same cycle; outstanding must not move.
    sb.push_back('{data: '0, layer: AW'(1)});
    step(1'b1, 1'b1, pat(8'hC3));
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b, required 0", err); end
    n_tests++; if (outstanding !== CW'(1)) begin n_fail++; $display("FAIL b2b_outstanding: got %0d, required 1", outstanding); end
    iter_start = 1'b1; step(1'b0, 1'b0, '0); iter_start = 1'b0;
    sb.push_back('{data: pat(8'hC3), layer: '0});
    step(1'b1, 1'b0, '0);
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_fill_reads();
    test_write_pattern();
    test_full_rw();
    test_rst_r();
    test_wr_reject();
    test_iter_concurrent();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish within 200000 time units");
    $fatal(1);
  end

endmodule
